// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizes for the memory port arbiter.
package mem_arb_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_MAX_WAIT = 15;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arbState;
    typedef enum logic {OWN_I, OWN_D} arbOwner;
endpackage

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr: counts memory wait cycles, flags the last one before abort.
module arb_timeout_ctr #(
    parameter int MAX_WAIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(MAX_WAIT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clock) begin
        if (reset || clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
    // this wait cycle brings the count to MAX_WAIT, so the access aborts now
    assign tc = cnt == W'(MAX_WAIT - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters.
// Define ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,
    output logic                busy,
    output logic                err
);
    arbState state, nextState;
    logic iReq, dReq, grantD, grantI, inBusy, done, timeout, finish, tc;
`ifdef ARB_RR_EN
    arbOwner lastGrant;
`endif
    // a requester still holds req during its ack cycle, so mask it there
    always_comb begin
        iReq = i_req & ~i_ack;
        dReq = d_req & ~d_ack;
`ifdef ARB_RR_EN
        grantD = dReq & (~iReq | lastGrant == OWN_I);
`else
        grantD = dReq;
`endif
        grantI = iReq & ~grantD;
    end
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end
    always_comb begin
        nextState = state == IDLE ? (grantD ? BUSY_D : grantI ? BUSY_I : IDLE)
                                  : (finish ? IDLE : state);
    end
    always_comb begin
        inBusy = state != IDLE;
        done = inBusy & m_ready;
        timeout = inBusy & ~m_ready & tc;
        finish = done | timeout;
        busy = inBusy;
    end
`ifdef ARB_RR_EN
    always_ff @(posedge clock) begin
        if (reset) lastGrant <= OWN_I;
        else if (state == IDLE && (grantD || grantI)) lastGrant <= grantD ? OWN_D : OWN_I;
    end
`endif
    arb_timeout_ctr #(.MAX_WAIT(MAX_WAIT)) uCtr (
        .clock(clock),
        .reset(reset),
        .clr(state == IDLE),
        .en(inBusy & ~m_ready),
        .tc(tc)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            m_req <= 1'b0;
            m_we <= 1'b0;
            m_addr <= '0;
            m_wdata <= '0;
            m_be <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err <= 1'b0;
        end else begin
            i_ack <= finish & (state == BUSY_I);
            d_ack <= finish & (state == BUSY_D);
            if (timeout) err <= 1'b1;
            if (state == IDLE && (grantD || grantI)) begin
                m_req <= 1'b1;
                m_we <= grantD & d_we;
                m_addr <= grantD ? d_addr : i_addr;
                m_wdata <= grantD ? d_wdata : '0;
                m_be <= grantD ? d_be : '1;
            end else if (finish) begin
                m_req <= 1'b0;
            end
            if (finish && state == BUSY_I) i_rdata <= timeout ? '0 : m_rdata;
            // completed stores leave d_rdata alone; an aborted one still zeroes it
            if (finish && state == BUSY_D && (timeout || !m_we)) d_rdata <= timeout ? '0 : m_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;
    typedef struct packed {logic isD; logic [31:0] data;} expT;
`ifdef ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif
    logic clock = 1'b0, reset = 1'b1;
    logic i_req = 0, d_req = 0, d_we = 0, i_ack, d_ack, m_req, m_we, m_ready = 0, busy, err;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, i_rdata, d_rdata, m_addr, m_wdata, m_rdata = 0;
    logic [3:0] d_be = 0, m_be;
    expT sbq[$];
    logic [31:0] accLog[$];
    logic [31:0] expDHold = 0;
    bit tbLastD = 0, memStuck = 0;
    int memDelay = 0, waitCnt = 0, total = 0, bad = 0;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a == 32'h40 ? 32'h00500093 : {a[15:0], ~a[15:0]};
    endfunction

    // memory model: ready after memDelay wait cycles, or never when stuck
    always @(negedge clock) begin
        if (!m_req) begin
            waitCnt = 0;
            m_ready = 0;
        end else begin
            m_ready = !memStuck && waitCnt == memDelay;
            m_rdata = memData(m_addr);
            waitCnt++;
        end
    end

    always @(posedge clock) if (m_req && m_ready) accLog.push_back(m_addr);

    // scoreboard: every ack must match the oldest expected completion
    always @(negedge clock) begin
        if (!reset && (i_ack || d_ack)) begin
            expT e;
            total++;
            if (i_ack && d_ack) begin
                bad++;
                $display("FAIL ack_exclusive: both acks high at %0t", $time);
            end else if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack: i_ack=%b d_ack=%b with nothing pending", i_ack, d_ack);
            end else begin
                e = sbq.pop_front();
                if (d_ack !== e.isD || (d_ack ? d_rdata : i_rdata) !== e.data) begin
                    bad++;
                    $display("FAIL ack_data: got port_d=%b data=%h, want port_d=%b data=%h",
                             d_ack, d_ack ? d_rdata : i_rdata, e.isD, e.data);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic run_fetch(input logic [31:0] a);
        bit got = 0;
        memStuck = 0;
        memDelay = 0;
        i_req = 1;
        i_addr = a;
        sbq.push_back({1'b0, memData(a)});
        for (int c = 0; c < 40 && !got; c++) begin
            tick;
            got = i_ack;
        end
        i_req = 0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL run_fetch: no i_ack for addr %h, want one", a);
        end
        tbLastD = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        tick;
        tick;
        total += 4;
        if ({m_req, m_we, i_ack, d_ack, busy, err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, want 000000", {m_req, m_we, i_ack, d_ack, busy, err});
        end
        if ({m_addr, m_wdata, m_be} !== 68'b0) begin
            bad++;
            $display("FAIL reset_mbus: got %h, want 0", {m_addr, m_wdata, m_be});
        end
        if (i_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_irdata: got %h, want 0", i_rdata);
        end
        if (d_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_drdata: got %h, want 0", d_rdata);
        end
        reset = 0;
        tick;
    endtask

    task automatic test_fetch;
        memDelay = 0;
        i_req = 1;
        i_addr = 32'h40;
        sbq.push_back({1'b0, 32'h00500093});
        tick;
        total += 3;
        if (m_req !== 1 || m_addr !== 32'h40 || m_we !== 0 || m_be !== 4'hF) begin
            bad++;
            $display("FAIL fetch_cycle1: m_req=%b m_addr=%h m_we=%b m_be=%h, want 1 40 0 f", m_req, m_addr, m_we, m_be);
        end
        if (i_ack !== 0) begin
            bad++;
            $display("FAIL fetch_early_ack: i_ack=%b in cycle 1, want 0", i_ack);
        end
        tick;
        if (i_ack !== 1 || i_rdata !== 32'h00500093) begin
            bad++;
            $display("FAIL fetch_cycle2: i_ack=%b i_rdata=%h, want 1 00500093", i_ack, i_rdata);
        end
        i_req = 0;
        tick;
        total += 2;
        if (i_ack !== 0) begin
            bad++;
            $display("FAIL fetch_ack_width: i_ack=%b after one cycle, want 0", i_ack);
        end
        if (i_rdata !== 32'h00500093) begin
            bad++;
            $display("FAIL fetch_hold: i_rdata=%h, want 00500093", i_rdata);
        end
        tbLastD = 0;
    endtask

    task automatic test_store;
        memDelay = 3;
        d_req = 1;
        d_we = 1;
        d_addr = 32'h100;
        d_wdata = 32'hDEADBEEF;
        d_be = 4'b0011;
        sbq.push_back({1'b1, expDHold});
        tick;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (m_req !== 1 || m_we !== 1 || m_addr !== 32'h100 || m_wdata !== 32'hDEADBEEF || m_be !== 4'b0011 || busy !== 1) begin
                bad++;
                $display("FAIL store_stable c%0d: m_req=%b we=%b addr=%h wdata=%h be=%b busy=%b", c, m_req, m_we, m_addr, m_wdata, m_be, busy);
            end
            d_addr = 32'h999 + c;
            d_wdata = $urandom;
            d_be = 4'b1100;
            d_we = 0;
            tick;
        end
        total++;
        if (d_ack !== 1 || d_rdata !== expDHold || m_req !== 0) begin
            bad++;
            $display("FAIL store_ack: d_ack=%b d_rdata=%h m_req=%b, want 1 %h 0", d_ack, d_rdata, m_req, expDHold);
        end
        d_req = 0;
        tick;
        tbLastD = 1;
    endtask

    task automatic test_contention(input logic [31:0] ia, input logic [31:0] da);
        bit firstD;
        int acks = 0;
        memDelay = 0;
        memStuck = 0;
        firstD = !(RR_EN && tbLastD);
        if (firstD) begin
            sbq.push_back({1'b1, memData(da)});
            sbq.push_back({1'b0, memData(ia)});
        end else begin
            sbq.push_back({1'b0, memData(ia)});
            sbq.push_back({1'b1, memData(da)});
        end
        expDHold = memData(da);
        i_req = 1;
        i_addr = ia;
        d_req = 1;
        d_we = 0;
        d_addr = da;
        tick;
        total++;
        if (m_addr !== (firstD ? da : ia)) begin
            bad++;
            $display("FAIL contention_grant: m_addr=%h, want %h", m_addr, firstD ? da : ia);
        end
        for (int c = 0; c < 20 && acks < 2; c++) begin
            tick;
            if (i_ack) begin i_req = 0; acks++; end
            if (d_ack) begin d_req = 0; acks++; end
        end
        total++;
        if (acks != 2) begin
            bad++;
            $display("FAIL contention_done: got %0d acks, want 2", acks);
        end
        i_req = 0;
        d_req = 0;
        tbLastD = !firstD;
        tick;
    endtask

    task automatic test_timeout;
        int cnt = 0;
        memStuck = 1;
        i_req = 1;
        i_addr = 32'h80;
        sbq.push_back({1'b0, 32'h0});
        tick;
        for (int c = 0; c < 40 && !i_ack; c++) begin
            cnt += int'(m_req);
            tick;
        end
        total += 2;
        if (cnt != 15 || m_req !== 0) begin
            bad++;
            $display("FAIL timeout_len: m_req cycles=%0d m_req=%b, want 15 0", cnt, m_req);
        end
        if (i_ack !== 1 || i_rdata !== 32'h0 || err !== 1) begin
            bad++;
            $display("FAIL timeout_ack: i_ack=%b i_rdata=%h err=%b, want 1 0 1", i_ack, i_rdata, err);
        end
        i_req = 0;
        memStuck = 0;
        tbLastD = 0;
        tick;
        run_fetch(32'h48);
        tick;
        total++;
        if (err !== 1) begin
            bad++;
            $display("FAIL err_sticky: err=%b after good access, want 1", err);
        end
    endtask

    task automatic test_reset_mid;
        memDelay = 5;
        d_req = 1;
        d_we = 0;
        d_addr = 32'h200;
        tick;
        tick;
        total++;
        if (busy !== 1 || m_req !== 1) begin
            bad++;
            $display("FAIL midreset_busy: busy=%b m_req=%b, want 1 1", busy, m_req);
        end
        reset = 1;
        tick;
        d_req = 0;
        total++;
        if (m_req !== 0 || busy !== 0 || d_ack !== 0 || err !== 0) begin
            bad++;
            $display("FAIL midreset_clear: m_req=%b busy=%b d_ack=%b err=%b, want 0000", m_req, busy, d_ack, err);
        end
        tick;
        reset = 0;
        tbLastD = 0;
        expDHold = 0;
        tick;
        total++;
        if (d_ack !== 0) begin
            bad++;
            $display("FAIL midreset_noack: d_ack=%b, want 0", d_ack);
        end
        run_fetch(32'h4C);
        tick;
    endtask

    task automatic test_ack_mask;
        bit got = 0;
        int n40 = 0, n44 = 0;
        accLog.delete();
        memDelay = 0;
        i_req = 1;
        i_addr = 32'h40;
        sbq.push_back({1'b0, memData(32'h40)});
        sbq.push_back({1'b0, memData(32'h44)});
        for (int c = 0; c < 20 && !got; c++) begin
            tick;
            got = i_ack;
        end
        tick;
        total++;
        if (m_req !== 0) begin
            bad++;
            $display("FAIL ackmask_regrant: m_req=%b m_addr=%h after ack cycle, want m_req 0", m_req, m_addr);
        end
        i_addr = 32'h44;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick;
            got = i_ack;
        end
        i_req = 0;
        tick;
        tick;
        foreach (accLog[k]) begin
            if (accLog[k] == 32'h40) n40++;
            if (accLog[k] == 32'h44) n44++;
        end
        total++;
        if (n40 != 1 || n44 != 1) begin
            bad++;
            $display("FAIL ackmask_count: accesses 0x40=%0d 0x44=%0d, want 1 1", n40, n44);
        end
        tbLastD = 0;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_store;
        test_contention(32'h60, 32'h300);
        test_timeout;
        test_contention(32'h64, 32'h304);
        test_reset_mid;
        test_ack_mask;
        repeat (3) tick;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d expected acks never seen, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the pipelined core's fetch stage (read-only) and memory stage (read/write).
- Grants one requester at a time and drives the registered memory request.
- Returns data plus a one-cycle acknowledge to the winner.
- A pending requester without ack is the stall source for the core's hazard logic.
- A watchdog aborts memory accesses that never complete.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables = DATA_W/8)
MAX_WAIT, 15, cycles a granted access may wait for m_ready before timeout abort (1..255)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch read request, held until i_ack
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetched instruction, valid in i_ack cycle, held afterwards
i_ack  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request, held until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  byte enables for stores
d_rdata  out  DATA_W  load data, valid in d_ack cycle, held afterwards
d_ack  out  1  one-cycle completion pulse for data
m_req  out  1  memory request, held until m_ready
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_be  out  DATA_W/8  memory byte enables
m_rdata  in  DATA_W  memory read data, valid with m_ready
m_ready  in  1  memory completes the access in any cycle where m_req=1 and m_ready=1
busy  out  1  1 while state != IDLE
err  out  1  sticky timeout flag

Behaviour:
- Reset: state=IDLE. All of m_req, m_we, m_addr, m_wdata, m_be, i_rdata, d_rdata, i_ack, d_ack, err, busy = 0. Timeout counter = 0. Any in-flight access is abandoned and no ack is issued.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, arbitration on the current cycle's inputs:
  - If d_req=1: latch d_addr/d_wdata/d_be/d_we into m_* registers, m_req<=1, go to BUSY_D.
  - Else if i_req=1: latch i_addr, m_we<=0, m_be<=all ones, m_req<=1, go to BUSY_I.
  - Ack mask: in the cycle an ack is high, that port's req is ignored, because the requester still holds req during its ack cycle. The other port may win in that cycle.
- BUSY_x, m_ready=1:
  - m_req<=0, x_ack<=1 next cycle, state<=IDLE.
  - Reads: x_rdata<=m_rdata.
  - Writes: d_rdata unchanged.
- BUSY_x, m_ready=0: counter increments. When counter reaches MAX_WAIT:
  - m_req<=0, err<=1 (sticky until reset), x_ack<=1 with x_rdata<=0, state<=IDLE.
- Counter clears on every IDLE->BUSY transition.
- Latency: req sampled cycle 0; m_req=1 in cycle 1; if m_ready=1 in cycle 1, ack in cycle 2. Back-to-back accesses therefore cost 2 cycles each at minimum.
- m_* outputs are stable for the whole BUSY interval. Input changes during BUSY are ignored.
- Acks are exclusive. Each is at most one cycle wide and never occurs without a prior grant.
- Fetch always presents m_we=0.

Optional Feature:
ARB_RR_EN
- Defined: a last-grant bit, reset to I, enables round-robin. When both reqs are high in IDLE, the port not granted last wins. A single requester always wins.
- Undefined: fixed data priority. Fetch may starve while d_req is continuously high. The bench must not assume fairness.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BUSY_I, BUSY_D), owner encoding (OWN_I, OWN_D), default ADDR_W/DATA_W/MAX_WAIT constants.
- One sub-module, arb_timeout_ctr: clear/enable inputs, terminal-count output, width $clog2(MAX_WAIT+1).

Test Plan:
- Fetch only: i_req=1, i_addr=0x40; m_ready=1 in first m_req cycle with m_rdata=0x00500093 -> m_addr=0x40 in cycle 1, i_ack=1 and i_rdata=0x00500093 in cycle 2, d_ack=0 throughout.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011; m_ready delayed 3 cycles -> m_* held stable 4 cycles, d_ack one cycle later, d_rdata unchanged.
- Contention, both reqs at cycle 0 -> data granted first. Then, after the d_ack mask, fetch is granted. Under ARB_RR_EN, with last grant = D, the next simultaneous request goes to fetch.
- Timeout: MAX_WAIT=15, m_ready stuck 0 -> m_req drops after 15 wait cycles, i_ack=1 with i_rdata=0, err=1 and stays 1 across later successful accesses.
- Reset mid-access: assert reset during BUSY_D -> next cycle m_req=0, busy=0, no d_ack. After reset release, a new fetch completes normally.
- Ack mask: i_req held high through the i_ack cycle, then a new i_addr=0x44 -> exactly one access per address, no duplicate read of 0x40.
